// File: rtl/pdu_pkg.sv
// Shared types and defaults for the PDU switch front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pdu_pkg;

    localparam int SW_WIDTH                = 16;
    localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;  // 10 ms at 100 MHz
    localparam int DEBOUNCE_CNT_W_DEFAULT  = 20;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        IDLE = 2'd1,
        WAIT = 2'd2
    } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a vector of independent asynchronous levels.
// Latency: a change sampled at edge E is visible on q after edge E+1.
// Backpressure: none; the input is sampled every cycle.
module sync_2ff #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // First stage may go metastable; second stage gives it a full cycle to resolve.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pdu_sw_debounce.sv
// Synchronise, debounce and commit the slide-switch vector; pulse the bits that changed.
// Latency: a clean raw change sampled at edge E commits at edge E+2+DEBOUNCE_CYCLES.
// Backpressure: none; sw_toggle/toggle_vld are single-cycle pulses the consumer must take.
module pdu_sw_debounce
    import pdu_pkg::*;
#(
    parameter int WIDTH           = SW_WIDTH,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,  // must be >= 2
    parameter int CNT_W           = DEBOUNCE_CNT_W_DEFAULT    // 2**CNT_W >= DEBOUNCE_CYCLES
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_stable,
    output logic [WIDTH-1:0] sw_toggle,
    output logic             toggle_vld,
    output logic             busy
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [WIDTH-1:0] sw_sync;
    logic [WIDTH-1:0] candidate;
    logic [CNT_W-1:0] cnt;
    state_t           state;

    sync_2ff #(
        .WIDTH (WIDTH)
    ) u_sync (
        .clk  (clk),
        .rstn (rstn),
        .d    (sw_raw),
        .q    (sw_sync)
    );

    // Single shared stability counter: any difference between the synchronised
    // vector and the candidate restarts the window; a full quiet window commits.
    // Pulse outputs default to 0 so they are high only on the commit cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= INIT;
            candidate  <= '0;
            cnt        <= '0;
            sw_stable  <= '0;
            sw_toggle  <= '0;
            toggle_vld <= 1'b0;
        end else begin
            sw_toggle  <= '0;
            toggle_vld <= 1'b0;
            case (state)
                // Learn the power-up switch positions without announcing them.
                INIT: begin
                    if (sw_sync != candidate) begin
                        candidate <= sw_sync;
                        cnt       <= '0;
                    end else if (cnt == CNT_MAX) begin
                        sw_stable <= candidate;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                IDLE: begin
                    if (sw_sync != sw_stable) begin
                        candidate <= sw_sync;
                        cnt       <= '0;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (sw_sync != candidate) begin
                        candidate <= sw_sync;
                        cnt       <= '0;
                    end else if (cnt == CNT_MAX) begin
                        // A bounce back to the old value commits silently (xor is 0).
                        sw_stable  <= candidate;
                        sw_toggle  <= candidate ^ sw_stable;
                        toggle_vld <= |(candidate ^ sw_stable);
                        state      <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= INIT;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Busy covers both power-up learning and a pending debounce window.
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_pdu_sw_debounce.sv
// Directed bench for pdu_sw_debounce with a 4-cycle debounce window.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// Models the downstream priority encoder to check the digit a toggle would produce.
module tb_pdu_sw_debounce;

    logic        clk;
    logic        rstn;
    logic [15:0] sw_raw;
    logic [15:0] sw_stable;
    logic [15:0] sw_toggle;
    logic        toggle_vld;
    logic        busy;

    int checks    = 0;
    int failures  = 0;
    int pulse_cnt = 0;
    int exp_pulse = 0;

    pdu_sw_debounce #(
        .WIDTH           (16),
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (3)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .sw_raw     (sw_raw),
        .sw_stable  (sw_stable),
        .sw_toggle  (sw_toggle),
        .toggle_vld (toggle_vld),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Highest set bit wins; 0 when nothing is set.
    function automatic logic [3:0] enc16(input logic [15:0] v);
        logic [3:0] r;
        r = 4'h0;
        for (int i = 0; i < 16; i++)
            if (v[i]) r = 4'(i);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one edge and count every cycle that shows a pulse.
    task automatic tick();
        @(posedge clk);
        #1;
        if (toggle_vld === 1'b1) pulse_cnt++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        // ---------------- power-up with 0005 held through reset
        rstn   = 1'b0;
        sw_raw = 16'h0005;
        #2;
        chk("rst_stable", sw_stable, 16'h0000);
        chk("rst_toggle", sw_toggle, 16'h0000);
        chk("rst_vld",    16'(toggle_vld), 16'h0000);
        chk("rst_busy",   16'(busy), 16'h0001);
        ticks(2);
        rstn = 1'b1;
        ticks(6);
        chk("init_busy_e5", 16'(busy), 16'h0001);
        tick();
        chk("init_busy_e6", 16'(busy), 16'h0000);
        chk("init_stable",  sw_stable, 16'h0005);
        ticks(3);
        chk("init_no_pulse", 16'(pulse_cnt), 16'(exp_pulse));

        // ---------------- return to 0000 (clears bits 0 and 2)
        sw_raw = 16'h0000;
        ticks(7);
        exp_pulse++;
        chk("clr_toggle", sw_toggle, 16'h0005);
        chk("clr_stable", sw_stable, 16'h0000);
        ticks(3);

        // ---------------- clean flip of bit 8
        sw_raw = 16'h0100;
        ticks(6);
        chk("b8_e5_vld",    16'(toggle_vld), 16'h0000);
        chk("b8_e5_stable", sw_stable, 16'h0000);
        tick();
        exp_pulse++;
        chk("b8_vld",    16'(toggle_vld), 16'h0001);
        chk("b8_toggle", sw_toggle, 16'h0100);
        chk("b8_stable", sw_stable, 16'h0100);
        chk("b8_enc",    16'(enc16(sw_toggle)), 16'h0008);
        tick();
        chk("b8_vld_off",    16'(toggle_vld), 16'h0000);
        chk("b8_toggle_off", sw_toggle, 16'h0000);
        chk("b8_busy_off",   16'(busy), 16'h0000);
        chk("b8_pulses",     16'(pulse_cnt), 16'(exp_pulse));

        // ---------------- bit 3 bounces for 10 cycles then settles high
        for (int i = 0; i < 10; i++) begin
            sw_raw = (i % 2 == 0) ? 16'h0108 : 16'h0100;
            tick();
        end
        chk("bnc_no_pulse", 16'(pulse_cnt), 16'(exp_pulse));
        sw_raw = 16'h0108;
        ticks(6);
        chk("bnc_e5_pulses", 16'(pulse_cnt), 16'(exp_pulse));
        tick();
        exp_pulse++;
        chk("bnc_vld",    16'(toggle_vld), 16'h0001);
        chk("bnc_toggle", sw_toggle, 16'h0008);
        chk("bnc_stable", sw_stable, 16'h0108);
        ticks(3);
        chk("bnc_pulses", 16'(pulse_cnt), 16'(exp_pulse));

        // ---------------- 2-cycle glitch on bit 7
        sw_raw = 16'h0188;
        ticks(2);
        sw_raw = 16'h0108;
        tick();
        chk("gl_busy_hi", 16'(busy), 16'h0001);
        ticks(12);
        chk("gl_busy_lo", 16'(busy), 16'h0000);
        chk("gl_stable",  sw_stable, 16'h0108);
        chk("gl_pulses",  16'(pulse_cnt), 16'(exp_pulse));

        // ---------------- back to 0000, then bits 2 and 12 two cycles apart
        sw_raw = 16'h0000;
        ticks(10);
        exp_pulse++;
        chk("z_stable", sw_stable, 16'h0000);
        sw_raw = 16'h0004;
        ticks(2);
        sw_raw = 16'h1004;
        ticks(6);
        chk("two_early_pulses", 16'(pulse_cnt), 16'(exp_pulse));
        tick();
        exp_pulse++;
        chk("two_vld",    16'(toggle_vld), 16'h0001);
        chk("two_toggle", sw_toggle, 16'h1004);
        chk("two_enc",    16'(enc16(sw_toggle)), 16'h000c);
        ticks(4);
        chk("two_pulses", 16'(pulse_cnt), 16'(exp_pulse));
        chk("two_stable", sw_stable, 16'h1004);

        // ---------------- reset while a 0020 change is pending
        sw_raw = 16'h0000;
        ticks(10);
        exp_pulse++;
        chk("r_pre_stable", sw_stable, 16'h0000);
        sw_raw = 16'h0020;
        ticks(4);
        chk("r_wait_busy", 16'(busy), 16'h0001);
        #2;
        rstn = 1'b0;
        #1;
        chk("r_async_stable", sw_stable, 16'h0000);
        chk("r_async_toggle", sw_toggle, 16'h0000);
        chk("r_async_vld",    16'(toggle_vld), 16'h0000);
        chk("r_async_busy",   16'(busy), 16'h0001);
        ticks(2);
        rstn = 1'b1;
        ticks(7);
        chk("r_init_busy",   16'(busy), 16'h0000);
        chk("r_init_stable", sw_stable, 16'h0020);
        ticks(4);
        chk("r_no_pulse", 16'(pulse_cnt), 16'(exp_pulse));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
